gpio_cmd_master: RTL

//  Hardware initiator for the GPIO command-word protocol: issues 32-bit command words (function code [15:0],

---
 rtl/gpio_cmd_pkg.sv | 72 +++++++
 rtl/gpio_cmd_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cmd_pkg.sv
// ---------------------------------------------------------------------------
// gpio_cmd_pkg
// Shared definitions for the GPIO command-word initiator: the local command
// op encoding, the FSM state type, the 16-bit function codes that go in the
// low half of a command word, the minimum hold/gap lengths, and helpers that
// build a command word and classify which words land in the response slot.
// ---------------------------------------------------------------------------
package gpio_cmd_pkg;

  typedef enum logic [2:0] {
    OP_START      = 3'd0,
    OP_INQUIRY    = 3'd1,
    OP_READ       = 3'd2,
    OP_STOP       = 3'd3,
    OP_DAC        = 3'd4,
    OP_HTRG       = 3'd5,
    OP_LTRG       = 3'd6,
    OP_READ_AVAIL = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP,
    ST_WAITRSP
  } state_e;

  localparam logic [15:0] FC_START   = 16'h0001;
  localparam logic [15:0] FC_INQUIRY = 16'h0002;
  localparam logic [15:0] FC_READ    = 16'h0004;
  localparam logic [15:0] FC_STOP    = 16'h0008;
  localparam logic [15:0] FC_DAC     = 16'h0010;
  localparam logic [15:0] FC_HTRG    = 16'h0020;
  localparam logic [15:0] FC_LTRG    = 16'h0040;

  // The decoder needs at least two cycles of a stable word, and at least one
  // all-zero cycle in between so that every command is seen as a fresh edge.
  localparam int HOLD_CYC_MIN = 2;
  localparam int GAP_CYC_MIN  = 1;

  // Builds {data, function code}. Only the level-setting ops carry data, and
  // only 14 bits of it. READ_AVAIL starts with an inquiry word and then
  // continues with plain read words.
  function automatic logic [31:0] cmd_word(input cmd_op_e op,
                                           input logic [15:0] arg,
                                           input logic inq_phase);
    logic [15:0] fc;
    logic [15:0] data;
    fc   = 16'h0000;
    data = 16'h0000;
    case (op)
      OP_START:      fc = FC_START;
      OP_INQUIRY:    fc = FC_INQUIRY;
      OP_READ:       fc = FC_READ;
      OP_STOP:       fc = FC_STOP;
      OP_DAC:        begin fc = FC_DAC;  data = {2'b00, arg[13:0]}; end
      OP_HTRG:       begin fc = FC_HTRG; data = {2'b00, arg[13:0]}; end
      OP_LTRG:       begin fc = FC_LTRG; data = {2'b00, arg[13:0]}; end
      OP_READ_AVAIL: fc = inq_phase ? FC_INQUIRY : FC_READ;
      default:       fc = 16'h0000;
    endcase
    return {data, fc};
  endfunction

  // True for any word whose return value is captured into the response slot.
  // The READ_AVAIL inquiry is consumed internally and never touches the slot.
  function automatic logic uses_slot(input cmd_op_e op, input logic inq_phase);
    return (op == OP_INQUIRY) || (op == OP_READ) ||
           ((op == OP_READ_AVAIL) && !inq_phase);
  endfunction

endpackage

// File: rtl/gpio_cmd_master.sv
// ---------------------------------------------------------------------------
// gpio_cmd_master
// Hardware initiator for the GPIO command-word protocol. Takes commands from a
// local valid/ready stream, drives 32-bit command words ({data, function code})
// onto SELECT_out for HOLD_CYC cycles followed by GAP_CYC all-zero cycles, and
// samples GPIO_in on the last hold cycle of inquiry/read words. Read data and
// inquiry results are returned through a single-entry response register.
//
// Ports
//   clk         single clock, all logic on posedge
//   reset       asynchronous, active-high
//   cmd_valid   command request
//   cmd_ready   high only while idle
//   cmd_op      START/INQUIRY/READ/STOP/DAC/HTRG/LTRG/READ_AVAIL
//   cmd_arg     level [13:0] for DAC/HTRG/LTRG, word count for READ/READ_AVAIL
//   SELECT_out  registered command word to the decoder
//   GPIO_in     return word from the decoder
//   rsp_valid   response held until rsp_ready
//   rsp_ready   response accept
//   rsp_data    INQUIRY: {15'b0, full, count}; READ: data word
//   rsp_last    last response of the current command
//   busy        FSM not idle or a response still pending
// ---------------------------------------------------------------------------
module gpio_cmd_master
  import gpio_cmd_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  output logic [31:0] SELECT_out,
  input  logic [31:0] GPIO_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        busy
);

  // Out-of-range parameters are clamped up to the protocol minimums.
  localparam int HOLD_EFF  = (HOLD_CYC < HOLD_CYC_MIN) ? HOLD_CYC_MIN : HOLD_CYC;
  localparam int GAP_EFF   = (GAP_CYC  < GAP_CYC_MIN)  ? GAP_CYC_MIN  : GAP_CYC;
  localparam int PHASE_MAX = (HOLD_EFF > GAP_EFF) ? HOLD_EFF : GAP_EFF;
  localparam int PW        = (PHASE_MAX > 2) ? $clog2(PHASE_MAX) : 1;
  localparam logic [PW-1:0] HOLD_LOAD = PW'(HOLD_EFF - 1);
  localparam logic [PW-1:0] GAP_LOAD  = PW'(GAP_EFF - 1);

  state_e        state, state_n;
  logic [PW-1:0] phase_cnt, phase_n;
  logic [15:0]   word_cnt, word_n;
  cmd_op_e       op_q, op_n;
  logic [15:0]   arg_q, arg_n;
  logic          inq_phase, inq_n;
  logic [31:0]   select_q, select_n;

  logic          capture;
  logic [31:0]   cap_data;
  logic          cap_last;

  cmd_op_e       new_op;
  logic          new_inq;
  logic          slot_free;
  logic          read_phase;
  logic [15:0]   avail_cnt;

  assign new_op     = cmd_op_e'(cmd_op);
  assign new_inq    = (new_op == OP_READ_AVAIL);
  // A response being drained this very cycle already counts as an empty slot.
  assign slot_free  = !rsp_valid || rsp_ready;
  assign read_phase = (op_q == OP_READ) || ((op_q == OP_READ_AVAIL) && !inq_phase);
  assign avail_cnt  = (GPIO_in[15:0] < arg_q) ? GPIO_in[15:0] : arg_q;

  assign SELECT_out = select_q;
  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE) || rsp_valid;

  // Next-state logic. The shared phase counter times both the hold and the
  // gap; the word counter holds the number of read words still to issue.
  // Slot-bound words wait in WAITRSP so a capture never overwrites an
  // unaccepted response.
  always_comb begin
    state_n  = state;
    phase_n  = phase_cnt;
    word_n   = word_cnt;
    op_n     = op_q;
    arg_n    = arg_q;
    inq_n    = inq_phase;
    select_n = select_q;
    capture  = 1'b0;
    cap_data = 32'h0000_0000;
    cap_last = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_n   = new_op;
          arg_n  = cmd_arg;
          inq_n  = new_inq;
          word_n = (new_op == OP_READ) ? cmd_arg : 16'h0000;
          if (!(((new_op == OP_READ) || (new_op == OP_READ_AVAIL)) && (cmd_arg == 16'h0000))) begin
            if (uses_slot(new_op, new_inq) && !slot_free) begin
              state_n = ST_WAITRSP;
            end else begin
              select_n = cmd_word(new_op, cmd_arg, new_inq);
              phase_n  = HOLD_LOAD;
              state_n  = ST_DRIVE;
            end
          end
        end
      end

      ST_DRIVE: begin
        if (phase_cnt == '0) begin
          select_n = 32'h0000_0000;
          phase_n  = GAP_LOAD;
          state_n  = ST_GAP;
          if (op_q == OP_INQUIRY) begin
            capture  = 1'b1;
            cap_data = {15'b0, GPIO_in[16:0]};
            cap_last = 1'b1;
          end else if ((op_q == OP_READ_AVAIL) && inq_phase) begin
            word_n = avail_cnt;
            inq_n  = 1'b0;
          end else if (read_phase) begin
            capture  = 1'b1;
            cap_data = GPIO_in;
            cap_last = (word_cnt == 16'h0001);
            word_n   = word_cnt - 16'h0001;
          end
        end else begin
          phase_n = phase_cnt - PW'(1);
        end
      end

      ST_GAP: begin
        if (phase_cnt == '0) begin
          if (read_phase && (word_cnt != 16'h0000)) begin
            if (slot_free) begin
              select_n = cmd_word(op_q, arg_q, inq_phase);
              phase_n  = HOLD_LOAD;
              state_n  = ST_DRIVE;
            end else begin
              state_n = ST_WAITRSP;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          phase_n = phase_cnt - PW'(1);
        end
      end

      ST_WAITRSP: begin
        if (slot_free) begin
          select_n = cmd_word(op_q, arg_q, inq_phase);
          phase_n  = HOLD_LOAD;
          state_n  = ST_DRIVE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // State and datapath registers. A fresh capture wins over the clear of an
  // accepted response, which keeps back-to-back responses seamless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      word_cnt  <= 16'h0000;
      op_q      <= OP_START;
      arg_q     <= 16'h0000;
      inq_phase <= 1'b0;
      select_q  <= 32'h0000_0000;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0000_0000;
      rsp_last  <= 1'b0;
    end else begin
      state     <= state_n;
      phase_cnt <= phase_n;
      word_cnt  <= word_n;
      op_q      <= op_n;
      arg_q     <= arg_n;
      inq_phase <= inq_n;
      select_q  <= select_n;
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_data  <= cap_data;
        rsp_last  <= cap_last;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
